mat_printer: RTL

Downstream consumer of the 3x3 matrix multiplier result. On a rising edge of the multiplier's `valid`, it snapshots the 9-element `C_mat` bus and streams it as ASCII hex text over a byte-wide valid/ready interface to the UART transmitter. One row is emitted per text line. The block sits between the multiplier and the UART TX in the lab top level.

---
 rtl/mat_printer.sv | 109 ++++++++++
 1 files changed

// File: rtl/mat_printer.sv
// mat_printer: snapshots an NxN result matrix on a rising c_valid and streams it as
// uppercase ASCII hex text, one row per CR/LF-terminated line, over a valid/ready byte port.
module mat_printer #(
   parameter int N      = 3,
   parameter int W      = 17,
   parameter int DIGITS = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               c_valid,
   input  logic [0:N*N*W-1]   C_mat,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               done
);
   localparam int RW = N > 1 ? $clog2(N) : 1;
   localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [RW-1:0] LAST_RC = RW'(N - 1);
   localparam logic [DW-1:0] LAST_D  = DW'(DIGITS - 1);
   typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF, FIN} state_t;
   state_t           state_q;
   logic [RW-1:0]    row_q, col_q;
   logic [DW-1:0]    dig_q;
   logic [0:N*N*W-1] snap_q;
   logic             cv_q;
   logic [7:0]       data_q;
   logic             valid_q, busy_q, done_q;
   logic             start, xfer;
   assign start    = c_valid & ~cv_q;
   assign xfer     = valid_q & tx_ready;
   assign tx_data  = data_q;
   assign tx_valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   // Digit d of element k (d = 0 is the most significant hex digit), as ASCII.
   function automatic logic [7:0] char_at(input logic [0:N*N*W-1] m, input int k, input int d);
      logic [DIGITS*4-1:0] ext;
      logic [3:0]          nib;
      ext = (DIGITS*4)'(m[k*W +: W]);
      nib = 4'(ext >> ((DIGITS - 1 - d) * 4));
      return nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
   endfunction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         dig_q   <= '0;
         snap_q  <= '0;
         cv_q    <= 1'b0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cv_q   <= c_valid;
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               snap_q  <= C_mat;
               row_q   <= '0;
               col_q   <= '0;
               dig_q   <= '0;
               data_q  <= char_at(C_mat, 0, 0);
               valid_q <= 1'b1;
               busy_q  <= 1'b1;
               state_q <= DIGIT;
            end
            DIGIT: if (xfer) begin
               if (dig_q != LAST_D) begin
                  dig_q  <= dig_q + DW'(1);
                  data_q <= char_at(snap_q, int'(row_q) * N + int'(col_q), int'(dig_q) + 1);
               end else begin
                  dig_q   <= '0;
                  data_q  <= col_q != LAST_RC ? 8'h20 : 8'h0D;
                  state_q <= col_q != LAST_RC ? SEP : CR;
               end
            end
            SEP: if (xfer) begin
               col_q   <= col_q + RW'(1);
               data_q  <= char_at(snap_q, int'(row_q) * N + int'(col_q) + 1, 0);
               state_q <= DIGIT;
            end
            CR: if (xfer) begin
               data_q  <= 8'h0A;
               state_q <= LF;
            end
            LF: if (xfer) begin
               if (row_q != LAST_RC) begin
                  row_q   <= row_q + RW'(1);
                  col_q   <= '0;
                  data_q  <= char_at(snap_q, (int'(row_q) + 1) * N, 0);
                  state_q <= DIGIT;
               end else begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  data_q  <= 8'h00;
                  state_q <= FIN;
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
